// File: rtl/tcam_pkg.sv
// Shared definitions for the banked TCAM routing memory: command encodings,
// default geometry and the default-geometry entry layout.
package tcam_pkg;

    localparam int DEF_ID_W     = 4;
    localparam int DEF_AXON_W   = 2;
    localparam int DEF_SYN_W    = 2;
    localparam int DEF_WEIGHT_W = 4;
    localparam int DEF_BITS     = DEF_ID_W + DEF_AXON_W + DEF_SYN_W;

    typedef enum logic [2:0] {
        MODE_I   = 3'b000,
        MODE_W   = 3'b001,
        MODE_R   = 3'b010,
        MODE_F   = 3'b011,
        MODE_C   = 3'b100,
        MODE_RST = 3'b101,
        MODE_FL  = 3'b110
    } mode_e;

    typedef struct packed {
        logic [DEF_BITS-1:0]     data;
        logic [DEF_BITS-1:0]     care;
        logic [DEF_WEIGHT_W-1:0] weight;
        logic                    valid;
    } entry_t;

endpackage

// File: rtl/tcam_route_mem_if.sv
// Command, read, compare and route bus of the TCAM routing memory.
interface tcam_route_mem_if
    import tcam_pkg::*;
#(
    parameter int ID_Width      = DEF_ID_W,
    parameter int Axon_Width    = DEF_AXON_W,
    parameter int Synapse_Width = DEF_SYN_W,
    parameter int AddressSize   = 4,
    parameter int Words         = 16,
    parameter int Banks         = 2,
    parameter int Weight_Width  = DEF_WEIGHT_W
);
    localparam int Bits  = ID_Width + Axon_Width + Synapse_Width;
    localparam int DST_W = Axon_Width + Synapse_Width;

    logic [2:0]              MODE;
    logic [Bits-1:0]         Data_In;
    logic [Bits-1:0]         Mskb_In;
    logic [AddressSize-1:0]  A_In;
    logic                    Dcs_In;
    logic                    Vbe_In;
    logic                    Vbi_In;
    logic [Weight_Width-1:0] Weight_In;
    logic [Banks-1:0]        Cbe_In;
    logic [ID_Width-1:0]     PacketID_In;
    logic [Bits-1:0]         Data_Out;
    logic                    Vb_Out;
    logic                    Rd_Valid;
    logic [Words-1:0]        Hitline_Out;
    logic                    Hit_Out;
    logic                    Cmp_Valid;
    logic [DST_W-1:0]        DstID_Out;
    logic [Weight_Width-1:0] Weight_Out;
    logic [AddressSize-1:0]  Route_Addr;
    logic                    Route_Valid;
    logic                    Route_Ready;
    logic                    Route_Last;
    logic                    Miss_Out;
    logic                    Busy_Out;

    modport master (
        output MODE, Data_In, Mskb_In, A_In, Dcs_In, Vbe_In, Vbi_In, Weight_In,
               Cbe_In, PacketID_In, Route_Ready,
        input  Data_Out, Vb_Out, Rd_Valid, Hitline_Out, Hit_Out, Cmp_Valid,
               DstID_Out, Weight_Out, Route_Addr, Route_Valid, Route_Last,
               Miss_Out, Busy_Out
    );

    modport slave (
        input  MODE, Data_In, Mskb_In, A_In, Dcs_In, Vbe_In, Vbi_In, Weight_In,
               Cbe_In, PacketID_In, Route_Ready,
        output Data_Out, Vb_Out, Rd_Valid, Hitline_Out, Hit_Out, Cmp_Valid,
               DstID_Out, Weight_Out, Route_Addr, Route_Valid, Route_Last,
               Miss_Out, Busy_Out
    );

endinterface

// File: rtl/tcam_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit, any-set flag and a
// flag telling whether that bit is the only one set.
module tcam_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic             only_one
);
    logic [N-1:0] vec_dec_s;

    // Scan from the top down so the lowest set bit wins last
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = vec[i] ? i[IDX_W-1:0] : idx;
        end
    end

    // Clearing the lowest set bit leaves nothing exactly when one bit is set
    assign vec_dec_s = vec - {{(N-1){1'b0}}, 1'b1};
    assign found     = |vec;
    assign only_one  = found && ((vec & vec_dec_s) == {N{1'b0}});

endmodule

// File: rtl/tcam_route_mem.sv
// Banked TCAM routing memory: ternary entry store with read, masked compare
// and a fire walker that emits every matching route through a handshake.
module tcam_route_mem
    import tcam_pkg::*;
#(
    parameter int ID_Width      = DEF_ID_W,
    parameter int Axon_Width    = DEF_AXON_W,
    parameter int Synapse_Width = DEF_SYN_W,
    parameter int AddressSize   = 4,
    parameter int Words         = 16,
    parameter int Banks         = 2,
    parameter int Weight_Width  = DEF_WEIGHT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    tcam_route_mem_if.slave bus
);
    localparam int Bits      = ID_Width + Axon_Width + Synapse_Width;
    localparam int DST_W     = Axon_Width + Synapse_Width;
    localparam int BANK_SIZE = Words / Banks;
    localparam logic [AddressSize:0] WORDS_L = Words[AddressSize:0];

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

    logic [Bits-1:0]         data_r [Words];
    logic [Bits-1:0]         care_r [Words];
    logic [Weight_Width-1:0] wgt_r  [Words];
    logic [Words-1:0]        valid_r;

    logic [1:0]              state_r;
    logic [1:0]              state_next_s;
    logic [Words-1:0]        pend_r;
    logic                    busy_r;
    logic                    miss_r;
    logic                    route_valid_r;
    logic                    route_last_r;
    logic [AddressSize-1:0]  route_addr_r;
    logic [DST_W-1:0]        route_dst_r;
    logic [Weight_Width-1:0] route_wgt_r;

    logic [Bits-1:0]         rd_data_r;
    logic                    rd_vb_r;
    logic                    rd_valid_r;
    logic [Words-1:0]        hitline_r;
    logic                    hit_r;
    logic                    cmp_valid_r;

    mode_e                   mode_s;
    logic                    cmd_ok_s;
    logic                    srst_s;
    logic                    addr_ok_s;
    logic                    accept_s;
    logic [Bits-1:0]         key_s;
    logic [Bits-1:0]         mask_s;
    logic [Banks-1:0]        ben_s;
    logic [Words-1:0]        hit_s;
    logic [Words-1:0]        clr_s;
    logic [Words-1:0]        pend_after_s;
    logic [Words-1:0]        enc_vec_s;
    logic [AddressSize-1:0]  enc_idx_s;
    logic                    enc_found_s;
    logic                    enc_one_s;

    function automatic logic entry_match(
        input logic [Bits-1:0] data,
        input logic [Bits-1:0] care,
        input logic [Bits-1:0] key,
        input logic [Bits-1:0] mask,
        input logic            valid
    );
        return valid && (((data ^ key) & care & mask) == {Bits{1'b0}});
    endfunction

    // Commands are only honoured while the fire walker is idle
    assign mode_s    = mode_e'(bus.MODE);
    assign cmd_ok_s  = (state_r == ST_IDLE);
    assign srst_s    = cmd_ok_s && (mode_s == MODE_RST);
    assign addr_ok_s = ({1'b0, bus.A_In} < WORDS_L);
    assign accept_s  = route_valid_r && bus.Route_Ready;

    // Search key: packet ID against the source-ID field during SEARCH, else the compare key
    always_comb begin
        key_s  = bus.Data_In;
        mask_s = bus.Mskb_In;
        ben_s  = bus.Cbe_In;
        if (state_r == ST_SEARCH) begin
            key_s  = {bus.PacketID_In, {(Bits-ID_Width){1'b0}}};
            mask_s = {{ID_Width{1'b1}}, {(Bits-ID_Width){1'b0}}};
            ben_s  = {Banks{1'b1}};
        end else begin
            key_s  = bus.Data_In;
            mask_s = bus.Mskb_In;
            ben_s  = bus.Cbe_In;
        end
    end

    // Per-entry match gated by the bank enable of the entry's bank
    always_comb begin
        hit_s = {Words{1'b0}};
        for (int i = 0; i < Words; i++) begin
            hit_s[i] = ben_s[i / BANK_SIZE] &&
                       entry_match(data_r[i], care_r[i], key_s, mask_s, valid_r[i]);
        end
    end

    // Encoder sees the fresh hit vector in SEARCH, the remaining hits after this accept in EMIT
    always_comb begin
        clr_s               = {Words{1'b0}};
        clr_s[route_addr_r] = 1'b1;
        pend_after_s        = pend_r & ~clr_s;
        if (state_r == ST_SEARCH) begin
            enc_vec_s = hit_s;
        end else begin
            enc_vec_s = pend_after_s;
        end
    end

    tcam_prio_enc #(
        .N     (Words),
        .IDX_W (AddressSize)
    ) u_prio_enc (
        .vec      (enc_vec_s),
        .idx      (enc_idx_s),
        .found    (enc_found_s),
        .only_one (enc_one_s)
    );

    // Fire walker next-state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mode_s == MODE_F) begin
                    state_next_s = ST_SEARCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (enc_found_s) begin
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (accept_s && route_last_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Entry storage: masked writes, flush, and both resets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Words; i++) begin
                data_r[i] <= {Bits{1'b0}};
                care_r[i] <= {Bits{1'b0}};
                wgt_r[i]  <= {Weight_Width{1'b0}};
            end
            valid_r <= {Words{1'b0}};
        end else if (srst_s) begin
            for (int i = 0; i < Words; i++) begin
                data_r[i] <= {Bits{1'b0}};
                care_r[i] <= {Bits{1'b0}};
                wgt_r[i]  <= {Weight_Width{1'b0}};
            end
            valid_r <= {Words{1'b0}};
        end else if (cmd_ok_s && (mode_s == MODE_W) && addr_ok_s) begin
            if (bus.Dcs_In) begin
                data_r[bus.A_In] <= (data_r[bus.A_In] & ~bus.Mskb_In) | (bus.Data_In & bus.Mskb_In);
                wgt_r[bus.A_In]  <= bus.Weight_In;
            end else begin
                care_r[bus.A_In] <= (care_r[bus.A_In] & ~bus.Mskb_In) | (bus.Data_In & bus.Mskb_In);
            end
            if (bus.Vbe_In) begin
                valid_r[bus.A_In] <= bus.Vbi_In;
            end
        end else if (cmd_ok_s && (mode_s == MODE_FL)) begin
            valid_r <= {Words{1'b0}};
        end
    end

    // Read and compare result registers; strobes pulse, results hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r   <= {Bits{1'b0}};
            rd_vb_r     <= 1'b0;
            rd_valid_r  <= 1'b0;
            hitline_r   <= {Words{1'b0}};
            hit_r       <= 1'b0;
            cmp_valid_r <= 1'b0;
        end else if (srst_s) begin
            rd_data_r   <= {Bits{1'b0}};
            rd_vb_r     <= 1'b0;
            rd_valid_r  <= 1'b0;
            hitline_r   <= {Words{1'b0}};
            hit_r       <= 1'b0;
            cmp_valid_r <= 1'b0;
        end else begin
            rd_valid_r  <= 1'b0;
            cmp_valid_r <= 1'b0;
            if (cmd_ok_s && (mode_s == MODE_R)) begin
                rd_valid_r <= 1'b1;
                if (addr_ok_s) begin
                    rd_data_r <= bus.Dcs_In ? data_r[bus.A_In] : care_r[bus.A_In];
                    rd_vb_r   <= valid_r[bus.A_In];
                end else begin
                    rd_data_r <= {Bits{1'b0}};
                    rd_vb_r   <= 1'b0;
                end
            end
            if (cmd_ok_s && (mode_s == MODE_C)) begin
                cmp_valid_r <= 1'b1;
                hitline_r   <= hit_s;
                hit_r       <= |hit_s;
            end
        end
    end

    // Fire walker: snapshot hits in SEARCH, then emit one route per accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            pend_r        <= {Words{1'b0}};
            miss_r        <= 1'b0;
            route_valid_r <= 1'b0;
            route_last_r  <= 1'b0;
            route_addr_r  <= {AddressSize{1'b0}};
            route_dst_r   <= {DST_W{1'b0}};
            route_wgt_r   <= {Weight_Width{1'b0}};
        end else if (srst_s) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            pend_r        <= {Words{1'b0}};
            miss_r        <= 1'b0;
            route_valid_r <= 1'b0;
            route_last_r  <= 1'b0;
            route_addr_r  <= {AddressSize{1'b0}};
            route_dst_r   <= {DST_W{1'b0}};
            route_wgt_r   <= {Weight_Width{1'b0}};
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            miss_r  <= 1'b0;
            case (state_r)
                ST_SEARCH: begin
                    pend_r <= hit_s;
                    if (enc_found_s) begin
                        route_valid_r <= 1'b1;
                        route_last_r  <= enc_one_s;
                        route_addr_r  <= enc_idx_s;
                        route_dst_r   <= data_r[enc_idx_s][DST_W-1:0];
                        route_wgt_r   <= wgt_r[enc_idx_s];
                    end else begin
                        miss_r <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (accept_s) begin
                        pend_r <= pend_after_s;
                        if (route_last_r) begin
                            route_valid_r <= 1'b0;
                            route_last_r  <= 1'b0;
                            route_addr_r  <= {AddressSize{1'b0}};
                            route_dst_r   <= {DST_W{1'b0}};
                            route_wgt_r   <= {Weight_Width{1'b0}};
                        end else begin
                            route_last_r <= enc_one_s;
                            route_addr_r <= enc_idx_s;
                            route_dst_r  <= data_r[enc_idx_s][DST_W-1:0];
                            route_wgt_r  <= wgt_r[enc_idx_s];
                        end
                    end
                end
                default: begin
                    pend_r <= pend_r;
                end
            endcase
        end
    end

    assign bus.Data_Out    = rd_data_r;
    assign bus.Vb_Out      = rd_vb_r;
    assign bus.Rd_Valid    = rd_valid_r;
    assign bus.Hitline_Out = hitline_r;
    assign bus.Hit_Out     = hit_r;
    assign bus.Cmp_Valid   = cmp_valid_r;
    assign bus.DstID_Out   = route_dst_r;
    assign bus.Weight_Out  = route_wgt_r;
    assign bus.Route_Addr  = route_addr_r;
    assign bus.Route_Valid = route_valid_r;
    assign bus.Route_Last  = route_last_r;
    assign bus.Miss_Out    = miss_r;
    assign bus.Busy_Out    = busy_r;

endmodule

// File: tb/tb_tcam_route_mem.sv
// Self-checking bench for tcam_route_mem: reference entry model plus a route
// scoreboard filled when a fire is issued and drained as routes are accepted.
module tb_tcam_route_mem;
    import tcam_pkg::*;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] dst;
        logic [3:0] weight;
        logic       last;
    } route_t;

    logic   clk;
    logic   rst_n;
    int     tests_run;
    int     tests_failed;
    entry_t model_q [16];
    route_t exp_q [$];

    tcam_route_mem_if bus ();

    tcam_route_mem dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            model_q[i] = '{data: 8'h00, care: 8'h00, weight: 4'h0, valid: 1'b0};
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic dcs, input logic [7:0] d,
                            input logic [7:0] m, input logic vbe, input logic vbi,
                            input logic [3:0] w);
        if (dcs) begin
            model_q[a].data   = (model_q[a].data & ~m) | (d & m);
            model_q[a].weight = w;
        end else begin
            model_q[a].care = (model_q[a].care & ~m) | (d & m);
        end
        if (vbe) model_q[a].valid = vbi;
        bus.MODE = MODE_W; bus.A_In = a; bus.Dcs_In = dcs; bus.Data_In = d;
        bus.Mskb_In = m; bus.Vbe_In = vbe; bus.Vbi_In = vbi; bus.Weight_In = w;
        tick();
        bus.MODE = MODE_I; bus.Vbe_In = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic dcs);
        logic [7:0] exp_d;
        exp_d = dcs ? model_q[a].data : model_q[a].care;
        bus.MODE = MODE_R; bus.A_In = a; bus.Dcs_In = dcs;
        tick();
        bus.MODE = MODE_I;
        check_eq({tag, "_rdvalid"}, bus.Rd_Valid, 1'b1);
        check_eq({tag, "_data"}, bus.Data_Out, exp_d);
        check_eq({tag, "_vb"}, bus.Vb_Out, model_q[a].valid);
        tick();
        check_eq({tag, "_rdpulse"}, bus.Rd_Valid, 1'b0);
        check_eq({tag, "_hold"}, bus.Data_Out, exp_d);
    endtask

    task automatic do_compare(input string tag, input logic [7:0] key, input logic [7:0] m,
                              input logic [1:0] cbe);
        logic [15:0] exp_h;
        exp_h = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            exp_h[i] = cbe[i / 8] && model_q[i].valid &&
                       (((model_q[i].data ^ key) & model_q[i].care & m) == 8'h00);
        end
        bus.MODE = MODE_C; bus.Data_In = key; bus.Mskb_In = m; bus.Cbe_In = cbe;
        tick();
        bus.MODE = MODE_I;
        check_eq({tag, "_cmpvalid"}, bus.Cmp_Valid, 1'b1);
        check_eq({tag, "_hitline"}, bus.Hitline_Out, exp_h);
        check_eq({tag, "_hit"}, bus.Hit_Out, |exp_h);
    endtask

    task automatic push_routes(input logic [3:0] pid);
        route_t r;
        for (int i = 0; i < 16; i++) begin
            if (model_q[i].valid && (((model_q[i].data[7:4] ^ pid) & model_q[i].care[7:4]) == 4'h0)) begin
                r.addr = i[3:0]; r.dst = model_q[i].data[3:0];
                r.weight = model_q[i].weight; r.last = 1'b0;
                exp_q.push_back(r);
            end
        end
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1].last = 1'b1;
    endtask

    task automatic check_route(input string tag, input route_t r);
        check_eq({tag, "_rvalid"}, bus.Route_Valid, 1'b1);
        check_eq({tag, "_raddr"}, bus.Route_Addr, r.addr);
        check_eq({tag, "_dst"}, bus.DstID_Out, r.dst);
        check_eq({tag, "_weight"}, bus.Weight_Out, r.weight);
        check_eq({tag, "_last"}, bus.Route_Last, r.last);
    endtask

    // stall cycles with Route_Ready=0 on the first route; optionally issue a W while stalled
    task automatic do_fire(input string tag, input logic [3:0] pid, input int stall, input logic wr_stall);
        route_t r;
        exp_q.delete();
        push_routes(pid);
        bus.MODE = MODE_F; bus.PacketID_In = pid; bus.Route_Ready = (stall == 0);
        tick();
        bus.MODE = MODE_I;
        check_eq({tag, "_busy_search"}, bus.Busy_Out, 1'b1);
        check_eq({tag, "_rv_search"}, bus.Route_Valid, 1'b0);
        tick();
        if (exp_q.size() == 0) begin
            check_eq({tag, "_miss"}, bus.Miss_Out, 1'b1);
            check_eq({tag, "_rv_miss"}, bus.Route_Valid, 1'b0);
            check_eq({tag, "_busy_miss"}, bus.Busy_Out, 1'b0);
            tick();
            check_eq({tag, "_miss_pulse"}, bus.Miss_Out, 1'b0);
            check_eq({tag, "_rv_after"}, bus.Route_Valid, 1'b0);
        end else begin
            check_eq({tag, "_nomiss"}, bus.Miss_Out, 1'b0);
            if (wr_stall) begin
                bus.MODE = MODE_W; bus.A_In = 4'd9; bus.Dcs_In = 1'b1; bus.Data_In = 8'h00;
                bus.Mskb_In = 8'hFF; bus.Vbe_In = 1'b1; bus.Vbi_In = 1'b0; bus.Weight_In = 4'h0;
            end
            for (int s = 0; s < stall; s++) begin
                check_route({tag, "_stall"}, exp_q[0]);
                tick();
            end
            bus.MODE = MODE_I; bus.Vbe_In = 1'b0; bus.Route_Ready = 1'b1;
            while (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check_route(tag, r);
                tick();
            end
            check_eq({tag, "_rv_done"}, bus.Route_Valid, 1'b0);
            check_eq({tag, "_busy_done"}, bus.Busy_Out, 1'b0);
        end
    endtask

    task automatic setup_entries();
        do_write(4'd3, 1'b1, 8'h5A, 8'hFF, 1'b1, 1'b1, 4'd2);
        do_write(4'd3, 1'b0, 8'hF0, 8'hFF, 1'b0, 1'b0, 4'd0);
        do_write(4'd9, 1'b1, 8'h5F, 8'hFF, 1'b1, 1'b1, 4'd7);
        do_write(4'd9, 1'b0, 8'hF0, 8'hFF, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rv"}, bus.Route_Valid, 1'b0);
        check_eq({tag, "_busy"}, bus.Busy_Out, 1'b0);
        check_eq({tag, "_raddr"}, bus.Route_Addr, 4'h0);
        check_eq({tag, "_dst"}, bus.DstID_Out, 4'h0);
        check_eq({tag, "_wgt"}, bus.Weight_Out, 4'h0);
        check_eq({tag, "_last"}, bus.Route_Last, 1'b0);
        check_eq({tag, "_miss"}, bus.Miss_Out, 1'b0);
        check_eq({tag, "_data"}, bus.Data_Out, 8'h00);
        check_eq({tag, "_vb"}, bus.Vb_Out, 1'b0);
        check_eq({tag, "_rdv"}, bus.Rd_Valid, 1'b0);
        check_eq({tag, "_hitline"}, bus.Hitline_Out, 16'h0000);
        check_eq({tag, "_hit"}, bus.Hit_Out, 1'b0);
        check_eq({tag, "_cmpv"}, bus.Cmp_Valid, 1'b0);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0;
        bus.MODE = MODE_I; bus.Data_In = 8'h00; bus.Mskb_In = 8'h00; bus.A_In = 4'h0;
        bus.Dcs_In = 1'b0; bus.Vbe_In = 1'b0; bus.Vbi_In = 1'b0; bus.Weight_In = 4'h0;
        bus.Cbe_In = 2'b00; bus.PacketID_In = 4'h0; bus.Route_Ready = 1'b0;
        model_clear();
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: two-hit fan-out with ready held high
        setup_entries();
        do_fire("fire1", 4'h5, 0, 1'b0);

        // 2: backpressure holds the first route; a W issued while busy is ignored
        do_fire("fire2", 4'h5, 3, 1'b1);
        do_read("rd9_after_busy_w", 4'd9, 1'b1);

        // 3: no matching entry
        do_fire("fire3", 4'hC, 0, 1'b0);

        // 4: bank-gated compares
        do_compare("cmp_b1", 8'h5A, 8'hFF, 2'b10);
        do_compare("cmp_b0", 8'h5A, 8'hFF, 2'b01);
        do_compare("cmp_both", 8'h50, 8'hF0, 2'b11);
        do_compare("cmp_none", 8'h5A, 8'hFF, 2'b00);
        do_read("rd3_care", 4'd3, 1'b0);

        // 5: flush clears valid bits only
        bus.MODE = MODE_FL;
        tick();
        bus.MODE = MODE_I;
        for (int i = 0; i < 16; i++) model_q[i].valid = 1'b0;
        do_read("rd3_flush", 4'd3, 1'b1);
        do_fire("fire_flush", 4'h5, 0, 1'b0);

        // soft reset command clears the whole array
        do_write(4'd5, 1'b1, 8'h33, 8'hFF, 1'b1, 1'b1, 4'd9);
        do_read("rd5_pre_srst", 4'd5, 1'b1);
        bus.MODE = MODE_RST;
        tick();
        bus.MODE = MODE_I;
        model_clear();
        check_all_zero("srst");
        do_read("rd5_srst", 4'd5, 1'b1);

        // 6: async reset in the middle of EMIT
        setup_entries();
        bus.MODE = MODE_F; bus.PacketID_In = 4'h5; bus.Route_Ready = 1'b0;
        tick();
        bus.MODE = MODE_I;
        tick();
        check_eq("emit_before_rst", bus.Route_Valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_clear();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        bus.Route_Ready = 1'b1;
        tick();
        check_eq("rv_after_rst", bus.Route_Valid, 1'b0);
        do_read("rd9_after_rst", 4'd9, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
